// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the memory access stage.
// Operation set, access sizes, stage FSM states and size/byte-count helpers.
package mem_pkg;

   typedef enum logic [4:0] {
      OP_NOP, OP_ADDI, OP_ADD, OP_LUI, OP_BEQ,
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD,
      OP_SB, OP_SH, OP_SW, OP_SD
   } instruction_type;

   typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef enum logic [1:0] {IDLE, BUS, HOLD} mem_state_t;

   function automatic logic is_memory_read(instruction_type op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD};
   endfunction

   function automatic logic is_memory(instruction_type op);
      return is_memory_read(op) || (op inside {OP_SB, OP_SH, OP_SW, OP_SD});
   endfunction

   function automatic logic is_write_reg(instruction_type op);
      return is_memory_read(op) || (op inside {OP_ADDI, OP_ADD, OP_LUI});
   endfunction

   function automatic msize_t size_of(instruction_type op);
      case (op)
         OP_LH, OP_LHU, OP_SH: return MSIZE2;
         OP_LW, OP_LWU, OP_SW: return MSIZE4;
         OP_LD, OP_SD:         return MSIZE8;
         default:              return MSIZE1;
      endcase
   endfunction

   function automatic logic [3:0] bytes_of(msize_t size);
      case (size)
         MSIZE2:  return 4'd2;
         MSIZE4:  return 4'd4;
         MSIZE8:  return 4'd8;
         default: return 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: access size, alignment check, store lane shifting
// and load data extraction with sign/zero extension.
module mem_align
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  instruction_type  op,
   input  logic [XLEN-1:0]  addr,
   input  logic [XLEN-1:0]  wdata,
   input  logic [XLEN-1:0]  rdata,
   output msize_t           size,
   output logic [7:0]       strobe,
   output logic [XLEN-1:0]  wdata_lane,
   output logic [XLEN-1:0]  rdata_ext,
   output logic             misalign
);

   logic [2:0]      off;
   logic [2:0]      amask;
   logic [7:0]      base;
   logic [XLEN-1:0] sh;

   always_comb begin
      size       = size_of(op);
      off        = addr[2:0];
      amask      = 3'(bytes_of(size) - 4'd1);
      base       = 8'((9'd1 << bytes_of(size)) - 9'd1);
      misalign   = is_memory(op) && ((off & amask) != 3'd0);
      strobe     = (is_memory(op) && !is_memory_read(op)) ? (base << off) : 8'h00;
      wdata_lane = wdata << {off, 3'b000};
      sh         = rdata >> {off, 3'b000};
      case (op)
         OP_LB:   rdata_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
         OP_LBU:  rdata_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
         OP_LH:   rdata_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
         OP_LHU:  rdata_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
         OP_LW:   rdata_ext = {{(XLEN-32){sh[31]}}, sh[31:0]};
         OP_LWU:  rdata_ext = {{(XLEN-32){1'b0}}, sh[31:0]};
         default: rdata_ext = sh;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: one instruction in flight, single data-bus
// transaction for aligned loads/stores, one-cycle pass-through otherwise.
//
// state | meaning
// IDLE  | empty, ready for a new instruction
// BUS   | data request outstanding, waiting for dresp_data_ok
// HOLD  | result offered to writeback
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  instruction_type  in_op,
   input  logic [63:0]      in_pc,
   input  logic [4:0]       in_rd,
   input  logic [XLEN-1:0]  in_result,
   input  logic [XLEN-1:0]  in_wdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_pc,
   output logic [4:0]       out_rd,
   output logic             out_write_reg,
   output logic [XLEN-1:0]  out_result,
   output logic             out_misalign,
   output logic             dreq_valid,
   output logic [XLEN-1:0]  dreq_addr,
   output msize_t           dreq_size,
   output logic [7:0]       dreq_strobe,
   output logic [XLEN-1:0]  dreq_data,
   input  logic             dresp_data_ok,
   input  logic [XLEN-1:0]  dresp_data
);

   mem_state_t      state, state_nx;
   logic            accept;
   instruction_type ld_op;
   instruction_type a_op;
   logic [XLEN-1:0] a_addr;
   msize_t          a_size;
   logic [7:0]      a_strobe;
   logic [XLEN-1:0] a_wdata;
   logic [XLEN-1:0] a_rdata;
   logic            a_mis;

   // Accepts never happen in BUS, so the aligner can be shared between
   // classifying the incoming op and extracting the outstanding load.
   assign a_op   = (state == BUS) ? ld_op : in_op;
   assign a_addr = (state == BUS) ? dreq_addr : in_result;

   mem_align #(.XLEN(XLEN)) u_align (
      .op         (a_op),
      .addr       (a_addr),
      .wdata      (in_wdata),
      .rdata      (dresp_data),
      .size       (a_size),
      .strobe     (a_strobe),
      .wdata_lane (a_wdata),
      .rdata_ext  (a_rdata),
      .misalign   (a_mis)
   );

   assign dreq_valid = (state == BUS);
   assign out_valid  = (state == HOLD);

   always_comb begin
      in_ready = 1'b0;
      state_nx = state;
      case (state)
         IDLE: in_ready = 1'b1;
         BUS:  if (dresp_data_ok) state_nx = HOLD;
         HOLD: begin
            in_ready = out_ready;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      accept = in_valid && in_ready;
      if (accept) state_nx = (is_memory(in_op) && !a_mis) ? BUS : HOLD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pc        <= '0;
         out_rd        <= '0;
         out_write_reg <= 1'b0;
         out_misalign  <= 1'b0;
         out_result    <= '0;
         ld_op         <= OP_NOP;
         dreq_addr     <= '0;
         dreq_size     <= MSIZE1;
         dreq_strobe   <= '0;
         dreq_data     <= '0;
      end else if (accept) begin
         out_pc        <= in_pc;
         out_rd        <= in_rd;
         out_write_reg <= is_write_reg(in_op) && !a_mis && (in_rd != 5'd0);
         out_misalign  <= a_mis;
         out_result    <= in_result;
         if (is_memory(in_op) && !a_mis) begin
            ld_op       <= in_op;
            dreq_addr   <= in_result;
            dreq_size   <= a_size;
            dreq_strobe <= a_strobe;
            dreq_data   <= a_wdata;
         end
      end else if (state == BUS && dresp_data_ok && is_memory_read(ld_op)) begin
         out_result <= a_rdata;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors push expected
// writeback results; a monitor pops and compares on each out handshake.
module tb_mem_access_stage;
   import mem_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   instruction_type in_op = OP_NOP;
   logic [63:0]     in_pc = '0;
   logic [4:0]      in_rd = '0;
   logic [63:0]     in_result = '0;
   logic [63:0]     in_wdata = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [63:0]     out_pc;
   logic [4:0]      out_rd;
   logic            out_write_reg;
   logic [63:0]     out_result;
   logic            out_misalign;
   logic            dreq_valid;
   logic [63:0]     dreq_addr;
   msize_t          dreq_size;
   logic [7:0]      dreq_strobe;
   logic [63:0]     dreq_data;
   logic            dresp_data_ok = 1'b0;
   logic [63:0]     dresp_data = '0;

   always #5 clk = ~clk;

   mem_access_stage #(.XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
      .in_rd(in_rd), .in_result(in_result), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
      .out_write_reg(out_write_reg), .out_result(out_result), .out_misalign(out_misalign),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
   );

   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic        wr;
      logic [63:0] res;
      logic        mis;
   } out_t;

   out_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] pc, input logic [4:0] rd, input logic wr,
                           input logic [63:0] res, input logic mis);
      out_t e;
      e.pc = pc; e.rd = rd; e.wr = wr; e.res = res; e.mis = mis;
      exp_q.push_back(e);
   endtask

   // Monitor: samples 2 time units after each falling edge, i.e. the values
   // the next rising edge will see.
   out_t mon_snap;
   logic mon_held = 1'b0;
   always @(negedge clk) begin
      out_t e;
      #2;
      if (out_valid) begin
         if (mon_held) begin
            chk("out_pc_hold", out_pc, mon_snap.pc);
            chk("out_result_hold", out_result, mon_snap.res);
            chk("out_ctl_hold", {out_rd, out_write_reg, out_misalign},
                {mon_snap.rd, mon_snap.wr, mon_snap.mis});
         end
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: got out_valid=1 pc=0x%0h, expected no result", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc", out_pc, e.pc);
               chk("out_rd", 64'(out_rd), 64'(e.rd));
               chk("out_write_reg", 64'(out_write_reg), 64'(e.wr));
               chk("out_result", out_result, e.res);
               chk("out_misalign", 64'(out_misalign), 64'(e.mis));
            end
            mon_held = 1'b0;
         end else begin
            mon_held = 1'b1;
            mon_snap.pc = out_pc; mon_snap.rd = out_rd; mon_snap.wr = out_write_reg;
            mon_snap.res = out_result; mon_snap.mis = out_misalign;
         end
      end else begin
         mon_held = 1'b0;
      end
   end

   // Presents an instruction and returns right at the accepting rising edge;
   // in_valid is left high so consecutive calls stream back to back.
   task automatic send(input instruction_type op, input logic [63:0] pc, input logic [4:0] rd,
                       input logic [63:0] res, input logic [63:0] wd, output int waits);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_pc = pc; in_rd = rd; in_result = res; in_wdata = wd;
      #2;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         #2;
         t++;
      end
      if (t >= 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready=0 for 20 cycles, expected 1");
      end
      waits = t;
      @(posedge clk);
   endtask

   task automatic finish_nonmem();
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk("nonmem_out_valid", 64'(out_valid), 64'd1);
      chk("nonmem_no_dreq", 64'(dreq_valid), 64'd0);
   endtask

   task automatic bus(input logic [63:0] addr, input msize_t sz, input logic [7:0] strb,
                      input logic [63:0] data, input int delay, input logic [63:0] rdata);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk("dreq_latency", 64'(dreq_valid), 64'd1);
      chk("dreq_addr", dreq_addr, addr);
      chk("dreq_size", 64'(dreq_size), 64'(sz));
      chk("dreq_strobe", 64'(dreq_strobe), 64'(strb));
      chk("dreq_data", dreq_data, data);
      repeat (delay) begin
         @(negedge clk);
         #2;
         chk("dreq_hold_valid", 64'(dreq_valid), 64'd1);
         chk("dreq_hold_addr", dreq_addr, addr);
         chk("dreq_hold_ctl", {54'd0, dreq_size, dreq_strobe}, {54'd0, sz, strb});
         chk("dreq_hold_data", dreq_data, data);
         chk("in_ready_bus", 64'(in_ready), 64'd0);
         chk("out_valid_bus", 64'(out_valid), 64'd0);
      end
      dresp_data = rdata;
      dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      dresp_data = '0;
      #2;
      chk("mem_out_valid", 64'(out_valid), 64'd1);
      chk("dreq_drop", 64'(dreq_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      #1 rst_n = 1'b0;
      @(negedge clk);
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_flags", {62'd0, out_write_reg, out_misalign}, 64'd0);
      chk("rst_dreq_strobe", 64'(dreq_strobe), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADDI pass-through
      push_exp(64'h100, 5'd5, 1'b1, 64'h1234, 1'b0);
      send(OP_ADDI, 64'h100, 5'd5, 64'h1234, 64'h0, w);
      finish_nonmem();

      // LB / LBU on the same byte 0x80
      push_exp(64'h104, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      send(OP_LB, 64'h104, 5'd6, 64'h1003, 64'h0, w);
      bus(64'h1003, MSIZE1, 8'h00, 64'h0, 0, 64'h0000_0000_8000_0000);
      push_exp(64'h108, 5'd7, 1'b1, 64'h80, 1'b0);
      send(OP_LBU, 64'h108, 5'd7, 64'h1003, 64'h0, w);
      bus(64'h1003, MSIZE1, 8'h00, 64'h0, 1, 64'h0000_0000_8000_0000);

      // SH lanes 6..7
      push_exp(64'h10C, 5'd9, 1'b0, 64'h2006, 1'b0);
      send(OP_SH, 64'h10C, 5'd9, 64'h2006, 64'hBEEF, w);
      bus(64'h2006, MSIZE2, 8'hC0, 64'hBEEF_0000_0000_0000, 2, 64'hDEAD);

      // misaligned LW
      push_exp(64'h110, 5'd8, 1'b0, 64'h1002, 1'b1);
      send(OP_LW, 64'h110, 5'd8, 64'h1002, 64'h0, w);
      finish_nonmem();

      // LD with slow bus and stalled writeback
      @(negedge clk);
      #1 out_ready = 1'b0;
      push_exp(64'h114, 5'd10, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
      send(OP_LD, 64'h114, 5'd10, 64'h3000, 64'h0, w);
      bus(64'h3000, MSIZE8, 8'h00, 64'h0, 5, 64'h0123_4567_89AB_CDEF);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      repeat (2) begin
         @(negedge clk);
         #2;
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_out_valid", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      #1 out_ready = 1'b1;

      // ADDI to x0 does not write
      push_exp(64'h118, 5'd0, 1'b0, 64'h55, 1'b0);
      send(OP_ADDI, 64'h118, 5'd0, 64'h55, 64'h0, w);
      finish_nonmem();

      // halfword / word extension
      push_exp(64'h11C, 5'd11, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
      send(OP_LH, 64'h11C, 5'd11, 64'h1002, 64'h0, w);
      bus(64'h1002, MSIZE2, 8'h00, 64'h0, 0, 64'h0000_0000_8001_0000);
      push_exp(64'h120, 5'd12, 1'b1, 64'h0000_0000_8765_4321, 1'b0);
      send(OP_LWU, 64'h120, 5'd12, 64'h4, 64'h0, w);
      bus(64'h4, MSIZE4, 8'h00, 64'h0, 1, 64'h8765_4321_0000_0000);
      push_exp(64'h124, 5'd13, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0);
      send(OP_LW, 64'h124, 5'd13, 64'h4, 64'h0, w);
      bus(64'h4, MSIZE4, 8'h00, 64'h0, 0, 64'h8765_4321_0000_0000);

      // SD full lanes, SB lane 5
      push_exp(64'h128, 5'd14, 1'b0, 64'h18, 1'b0);
      send(OP_SD, 64'h128, 5'd14, 64'h18, 64'h1122_3344_5566_7788, w);
      bus(64'h18, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0);
      push_exp(64'h12C, 5'd15, 1'b0, 64'h5, 1'b0);
      send(OP_SB, 64'h12C, 5'd15, 64'h5, 64'hAB, w);
      bus(64'h5, MSIZE1, 8'h20, 64'h0000_AB00_0000_0000, 1, 64'h0);

      // back-to-back non-memory ops
      push_exp(64'h130, 5'd1, 1'b1, 64'h11, 1'b0);
      push_exp(64'h134, 5'd2, 1'b1, 64'h22, 1'b0);
      push_exp(64'h138, 5'd3, 1'b1, 64'h33, 1'b0);
      send(OP_ADDI, 64'h130, 5'd1, 64'h11, 64'h0, w);
      send(OP_ADDI, 64'h134, 5'd2, 64'h22, 64'h0, w);
      chk("b2b_waits", 64'(w), 64'd0);
      send(OP_ADD, 64'h138, 5'd3, 64'h33, 64'h0, w);
      chk("b2b_waits", 64'(w), 64'd0);
      finish_nonmem();

      // reset during BUS abandons the load
      send(OP_LD, 64'h13C, 5'd4, 64'h5000, 64'h0, w);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      chk("pre_rst_dreq_valid", 64'(dreq_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_dreq", 64'(dreq_valid), 64'd0);
      chk("rst_async_out_valid", 64'(out_valid), 64'd0);
      chk("rst_async_result", out_result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      dresp_data_ok = 1'b1;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #2;
         chk("post_rst_out_valid", 64'(out_valid), 64'd0);
         chk("post_rst_dreq_valid", 64'(dreq_valid), 64'd0);
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline memory stage between execute and writeback. Accepts one executed instruction per handshake, classifies it with the team's `is_memory`, `is_memory_read` and `is_write_reg` decode helpers, and performs a single data-bus transaction for loads and stores. Non-memory instructions pass through with one cycle of latency. Loads return sign- or zero-extended data to writeback.

## Interface
Parameters:
- `XLEN`, 64, datapath width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  execute offers an instruction.
- `in_ready`  out  1  stage accepts when `in_valid & in_ready`.
- `in_op`  in  instruction_type  decoded operation.
- `in_pc`  in  64  instruction PC.
- `in_rd`  in  5  destination register.
- `in_result`  in  64  ALU result; this is the effective address for loads and stores.
- `in_wdata`  in  64  store data (rs2), right-aligned.
- `out_valid`  out  1  result offered to writeback.
- `out_ready`  in  1  writeback consumes when `out_valid & out_ready`.
- `out_pc`  out  64  registered PC.
- `out_rd`  out  5  registered destination register.
- `out_write_reg`  out  1  result must be written to `out_rd`.
- `out_result`  out  64  load data or the passed-through `in_result`.
- `out_misalign`  out  1  access was misaligned; no bus access was made.
- `dreq_valid`  out  1  data request.
- `dreq_addr`  out  64  request address.
- `dreq_size`  out  msize_t  access size.
- `dreq_strobe`  out  8  byte write enables; zero for loads.
- `dreq_data`  out  64  lane-shifted store data.
- `dresp_data_ok`  in  1  transaction complete.
- `dresp_data`  in  64  raw 64-bit load word.

## Operation
FSM states: IDLE, BUS, HOLD.
- **IDLE:**
  - `in_ready`=1.
  - On accept of a non-memory op, or of a misaligned memory op: latch the fields, go to HOLD.
  - On accept of an aligned memory op: latch the fields and the request, go to BUS.
- **BUS:**
  - `dreq_valid`=1.
  - All `dreq_*` outputs stay stable until `dresp_data_ok`.
  - On `dresp_data_ok`: latch the load result, go to HOLD.
  - `in_ready`=0.
- **HOLD:**
  - `out_valid`=1.
  - On `out_ready`: go to IDLE, or accept the next instruction in the same cycle.
  - `in_ready`=`out_ready`.

Alignment: the access is misaligned if `addr & (size-1) != 0`. A misaligned access sets `out_misalign`=1 and `out_write_reg`=0, and issues no bus request.

Sizes: B/BU=1, H/HU=2, W/WU=4, D=8 bytes.

Store lane rules:
- `strobe = ((1<<bytes)-1) << addr[2:0]`
- `dreq_data = in_wdata << (8*addr[2:0])`

Load rules:
- Shift `dresp_data` right by `8*addr[2:0]`.
- Truncate to the access size.
- LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD is unchanged.

Write-back rules:
- `out_write_reg` = `is_write_reg(op)` & !misalign & (`in_rd` != 0).
- Stores produce `out_write_reg`=0.

Reset:
- All outputs are 0 and the state is IDLE.
- Asserting reset during BUS drops `dreq_valid` immediately and abandons the transaction.
- A `dresp_data_ok` that arrives after reset is ignored.

## Timing
- Non-memory op: accepted at cycle N, `out_valid` at N+1.
- Memory op: accepted at N, `dreq_valid` from N+1. If `dresp_data_ok` arrives at M, `out_valid` is asserted at M+1.
- Minimum load latency is 2 cycles (`dresp_data_ok` at N+1).
- Back-to-back throughput: one non-memory op per cycle when `out_ready` stays high.
- `dresp_data_ok` is only sampled in BUS.
- `out_*` outputs hold stable while `out_valid & !out_ready`.

## Structure
- Shared package `mem_pkg`:
  - `msize_t` (MSIZE1, MSIZE2, MSIZE4, MSIZE8).
  - `mem_state_t`.
  - A `bytes_of(msize_t)` helper.
- Sub-module `mem_align`, purely combinational:
  - Inputs: op, addr, wdata, raw rdata.
  - Outputs: size, strobe, shifted wdata, extended rdata, misalign.

## Test plan
- ADDI result 0x1234, rd=5 → `out_valid` next cycle, `out_result`=0x1234, `out_write_reg`=1, no `dreq_valid`.
- LB at addr 0x1003, `dresp_data`=0x00000000_80000000 → `dreq_size`=MSIZE1, `dreq_strobe`=0; result 0xFFFF_FFFF_FFFF_FF80. The same access with LBU gives 0x80.
- SH at addr 0x2006 with wdata 0xBEEF → `dreq_strobe`=0xC0, `dreq_data`=0xBEEF_0000_0000_0000, `out_write_reg`=0.
- LW at addr 0x1002 → `out_misalign`=1, no bus request, `out_valid` next cycle, `out_write_reg`=0.
- LD with `dresp_data_ok` delayed 5 cycles and `out_ready` low 3 cycles → `dreq_*` and then `out_*` held stable throughout, `in_ready`=0 until the handoff.
- `rst_n` pulled low during BUS → `dreq_valid`=0 asynchronously; a later `dresp_data_ok` produces no `out_valid`.
